// File: rtl/hazard_controller_if.sv
// Pipeline hazard signalling between the core pipeline and the hazard controller.
// The pipeline side drives requests and exceptions; the controller returns the freeze/flush controls.
interface hazard_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 load_related_1;
    logic                 load_related_2;
    logic                 stall_req_if;
    logic                 stall_req_ex;
    logic                 stall_req_mem;
    logic                 exc_flag;
    logic [31:0]          exc_pc;
    logic                 cnt_clear;
    logic [4:0]           stall;
    logic                 flush;
    logic [31:0]          flush_pc;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic                 stall_timeout;

    modport master (
        output load_related_1, load_related_2, stall_req_if, stall_req_ex,
               stall_req_mem, exc_flag, exc_pc, cnt_clear,
        input  stall, flush, flush_pc, stall_cycles, stall_timeout
    );

    modport slave (
        input  load_related_1, load_related_2, stall_req_if, stall_req_ex,
               stall_req_mem, exc_flag, exc_pc, cnt_clear,
        output stall, flush, flush_pc, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: prioritised stall generation, exception flush sequencing,
// stall-cycle statistics and a sticky stall watchdog.
module hazard_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard_controller_if.slave bus
);
    typedef enum logic [1:0] {RUN, EXC_PEND, FLUSH} state_t;

    localparam logic [7:0]           LP_RUN_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE  = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_next;
    logic [4:0]           w_stall;
    logic                 w_exc_take;
    logic [31:0]          r_flush_pc;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [7:0]           r_run_len;
    logic                 r_timeout;

    // Only a RUN-state exception is accepted; later ones are dropped so the first wins.
    assign w_exc_take = (r_state == RUN) && bus.exc_flag;

    always_comb begin
        w_stall = 5'b00000;
        if (rst || r_state == FLUSH)
            w_stall = 5'b00000;
        else if (r_state == EXC_PEND || w_exc_take || bus.stall_req_mem)
            w_stall = 5'b11111;
        else if (bus.stall_req_ex)
            w_stall = 5'b01111;
        else if (bus.load_related_1 || bus.load_related_2)
            w_stall = 5'b00111;
        else if (bus.stall_req_if)
            w_stall = 5'b00011;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:      if (bus.exc_flag) w_next = bus.stall_req_mem ? EXC_PEND : FLUSH;
            EXC_PEND: if (!bus.stall_req_mem) w_next = FLUSH;
            FLUSH:    w_next = RUN;
            default:  w_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_flush_pc     <= 32'h0;
            r_stall_cycles <= '0;
            r_run_len      <= 8'h0;
            r_timeout      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_exc_take)
                r_flush_pc <= bus.exc_pc;
            if (bus.cnt_clear)
                r_stall_cycles <= '0;
            else if (w_stall[0])
                r_stall_cycles <= r_stall_cycles + LP_CNT_ONE;
            if (!w_stall[0])
                r_run_len <= 8'h0;
            else if (r_run_len != 8'hFF)
                r_run_len <= r_run_len + 8'h1;
            // Set on the edge where the run length becomes TIMEOUT_CYCLES; sticky until reset.
            if (w_stall[0] && r_run_len == LP_RUN_LAST)
                r_timeout <= 1'b1;
        end
    end

    assign bus.stall         = w_stall;
    assign bus.flush         = !rst && (r_state == FLUSH);
    assign bus.flush_pc      = r_flush_pc;
    assign bus.stall_cycles  = r_stall_cycles;
    assign bus.stall_timeout = r_timeout;
endmodule
